// File: rtl/reg_load_arbiter_if.sv
// rtl/reg_load_arbiter_if.sv - requester/register-bus bundle for reg_load_arbiter
//
// Purpose: groups the two requester channels, the control-unit freeze and the
// shared register write bus into one interface.
// Signals:
//   hold              freeze, no new grant while 1
//   req0/dest0/data0  requester 0 request, target (0=A, 1=B), write data
//   req1/dest1/data1  requester 1, same meaning
//   ack0/ack1         one-cycle grant acknowledges
//   load_a/load_b     load strobes to register A / register B
//   data_out          shared data bus to both registers
//   contend           one-cycle pulse, both requesters were eligible
// Modports: master = requesters/control side, slave = arbiter side.
interface reg_load_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             hold;
    logic             req0;
    logic             dest0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic             dest1;
    logic [WIDTH-1:0] data1;
    logic             ack0;
    logic             ack1;
    logic             load_a;
    logic             load_b;
    logic [WIDTH-1:0] data_out;
    logic             contend;

    modport master (
        output hold, req0, dest0, data0, req1, dest1, data1,
        input  ack0, ack1, load_a, load_b, data_out, contend
    );

    modport slave (
        input  hold, req0, dest0, data0, req1, dest1, data1,
        output ack0, ack1, load_a, load_b, data_out, contend
    );
endinterface

// File: rtl/reg_load_arbiter.sv
// rtl/reg_load_arbiter.sv - two-requester round-robin arbiter for a shared register write bus
//
// Purpose: grants one of two write requesters per cycle onto the shared data
// bus feeding registers A and B, with registered (latency 1) outputs.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    reg_load_arbiter_if.slave (hold, req/dest/data x2 in;
//          ack0/ack1, load_a/load_b, data_out, contend out)
module reg_load_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_load_arbiter_if.slave    bus
);
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             load_a_q, load_a_d;
    logic             load_b_q, load_b_d;
    logic             contend_q, contend_d;
    logic [WIDTH-1:0] data_q, data_d;
    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic             ptr_q, ptr_d;

    logic elig0, elig1, grant0, grant1;

    // A requester whose ack is currently high is already being served this
    // cycle; excluding it prevents a held req from being granted twice.
    assign elig0 = bus.req0 && !ack0_q && !bus.hold;
    assign elig1 = bus.req1 && !ack1_q && !bus.hold;

    assign grant0 = elig0 && (!elig1 || !ptr_q);
    assign grant1 = elig1 && (!elig0 ||  ptr_q);

    always_comb begin
        ack0_d    = grant0;
        ack1_d    = grant1;
        load_a_d  = (grant0 && !bus.dest0) || (grant1 && !bus.dest1);
        load_b_d  = (grant0 &&  bus.dest0) || (grant1 &&  bus.dest1);
        contend_d = elig0 && elig1;
        data_d    = data_q;
        ptr_d     = ptr_q;
        if (grant0) begin
            data_d = bus.data0;
            ptr_d  = 1'b1;
        end else if (grant1) begin
            data_d = bus.data1;
            ptr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            load_a_q  <= 1'b0;
            load_b_q  <= 1'b0;
            contend_q <= 1'b0;
            data_q    <= '0;
            ptr_q     <= 1'b0;
        end else begin
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            load_a_q  <= load_a_d;
            load_b_q  <= load_b_d;
            contend_q <= contend_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.load_a   = load_a_q;
    assign bus.load_b   = load_b_q;
    assign bus.contend  = contend_q;
    assign bus.data_out = data_q;
endmodule
